sme_loader: RTL and testbench

- Upstream feeder for the string-matching engine (SME).
- Accepts a tagged byte stream over a valid/ready handshake and buffers one string (≤32 chars) and one pattern (≤8 chars).
- Replays them into the SME's chardata/isstring/ispattern protocol, waits for the SME's valid pulse, then issues the next pattern.
- Hides SME timing rules (contiguous bursts, idle gap to trigger matching) from the producer.

---
 rtl/sme_pkg.sv | 20 ++
 rtl/sme_byte_buf.sv | 53 +++++
 rtl/sme_loader.sv | 247 ++++++++++++++++++++++++
 tb/tb_sme_loader.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sme_pkg.sv
// Shared constants and types for the SME loader: character codes, input
// type codes, default buffer depths and the loader state encoding.
package sme_pkg;

  localparam logic [7:0] CH_HAT    = 8'h5E;
  localparam logic [7:0] CH_DOT    = 8'h2E;
  localparam logic [7:0] CH_DOLLAR = 8'h24;
  localparam logic [7:0] CH_SPACE  = 8'h20;

  localparam logic [1:0] TYPE_STR = 2'b00;
  localparam logic [1:0] TYPE_PAT = 2'b01;
  localparam logic [1:0] TYPE_EOS = 2'b10;
  localparam logic [1:0] TYPE_RSV = 2'b11;

  localparam int STR_MAX_DEF = 32;
  localparam int PAT_MAX_DEF = 8;

  typedef enum logic [2:0] {IDLE, SEND_STR, SEND_PAT, WAIT, DONE} state_e;

endpackage

// File: rtl/sme_byte_buf.sv
// DEPTH x 8 register buffer filled from index 0. clr_i restarts the record
// and may coincide with the first write. Writes past DEPTH are dropped and
// flagged on ovf_o in the same cycle. Contents are readable by index and as
// a flat vector for whole-buffer copies.
module sme_byte_buf #(
  parameter  int DEPTH = 8,
  localparam int LW    = $clog2(DEPTH + 1),
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               clr_i,
  input  logic               we_i,
  input  logic [7:0]         wdata_i,
  input  logic [AW-1:0]      raddr_i,
  output logic [7:0]         rdata_o,
  output logic [LW-1:0]      len_o,
  output logic               ovf_o,
  output logic [DEPTH*8-1:0] mem_o
);

  logic [7:0]    mem_q [DEPTH];
  logic [LW-1:0] len_q, len_d, wptr;
  logic          wr;

  // Write pointer restarts on clr; a full buffer turns the write into a drop.
  always_comb begin
    wptr  = clr_i ? '0 : len_q;
    ovf_o = we_i && (wptr == LW'(DEPTH));
    wr    = we_i && !ovf_o;
    len_d = wr ? wptr + 1'b1 : wptr;
  end

  // Fill level is control state and clears on reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) len_q <= '0;
    else         len_q <= len_d;
  end

  // Byte storage; contents are meaningless beyond len_q so no reset.
  always_ff @(posedge clk_i) begin
    if (wr) mem_q[wptr[AW-1:0]] <= wdata_i;
  end

  // Flatten storage for parallel copy.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) mem_o[i*8 +: 8] = mem_q[i];
  end

  assign rdata_o = mem_q[raddr_i];
  assign len_o   = len_q;

endmodule

// File: rtl/sme_loader.sv
// Upstream feeder for the string-matching engine. Buffers one string and
// one pattern from a tagged valid/ready byte stream, replays them as
// contiguous isstring/ispattern bursts, then waits for the SME result pulse.
// Optional build macro SME_LOADER_TIMEOUT_EN adds a WAIT-state watchdog.
module sme_loader
  import sme_pkg::*;
#(
  parameter int STR_MAX = STR_MAX_DEF,
  parameter int PAT_MAX = PAT_MAX_DEF,
  parameter int TIMEOUT = 64
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] in_data,
  input  logic [1:0] in_type,
  input  logic       in_last,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [7:0] chardata,
  output logic       isstring,
  output logic       ispattern,
  input  logic       sme_valid,
  output logic       busy,
  output logic [7:0] pat_cnt,
  output logic       err
);

  localparam int SLW  = $clog2(STR_MAX + 1);
  localparam int SAW  = $clog2(STR_MAX);
  localparam int PLW  = $clog2(PAT_MAX + 1);
  localparam int PAW  = $clog2(PAT_MAX);
  localparam int IMAX = (STR_MAX > PAT_MAX) ? STR_MAX : PAT_MAX;
  localparam int IW   = $clog2(IMAX + 1);

  state_e           state_q, state_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic             str_valid_q, str_valid_d, str_sent_q, str_sent_d;
  logic             pat_full_q, pat_full_d;
  logic             str_first_q, str_first_d, pat_first_q, pat_first_d;
  logic             err_q, err_d;
  logic [7:0]       pat_cnt_q, pat_cnt_d, chardata_q, chardata_d;
  logic             isstring_q, isstring_d, ispattern_q, ispattern_d;
  logic [7:0]       iss_q [PAT_MAX];
  logic [PLW-1:0]   iss_len_q;
  logic             go_pat, acc, acc_str, acc_pat, acc_eos;
  logic [7:0]       str_rdata, pat_rdata;
  logic [SLW-1:0]   str_len;
  logic [PLW-1:0]   pat_len;
  logic             str_ovf, pat_ovf, pat_we;
  logic [STR_MAX*8-1:0] unused_str_mem;
  logic [PAT_MAX*8-1:0] pat_mem;

  // Ready depends on byte type: strings and EOS only in IDLE, patterns
  // whenever the pattern buffer is free; nothing is taken in DONE or reset.
  always_comb begin
    in_ready = 1'b0;
    if (reset && state_q != DONE) begin
      case (in_type)
        TYPE_STR, TYPE_EOS: in_ready = (state_q == IDLE) && !pat_full_q;
        TYPE_PAT:           in_ready = !pat_full_q;
        default:            in_ready = 1'b1;
      endcase
    end
  end

  assign acc     = in_valid && in_ready;
  assign acc_str = acc && (in_type == TYPE_STR);
  assign acc_pat = acc && (in_type == TYPE_PAT);
  assign acc_eos = acc && (in_type == TYPE_EOS);
  assign pat_we  = acc_pat && str_valid_q;

  sme_byte_buf #(.DEPTH(STR_MAX)) u_str_buf (
    .clk_i(clk), .rst_ni(reset), .clr_i(acc_str && str_first_q), .we_i(acc_str),
    .wdata_i(in_data), .raddr_i(idx_q[SAW-1:0]), .rdata_o(str_rdata),
    .len_o(str_len), .ovf_o(str_ovf), .mem_o(unused_str_mem)
  );

  sme_byte_buf #(.DEPTH(PAT_MAX)) u_pat_buf (
    .clk_i(clk), .rst_ni(reset), .clr_i(pat_we && pat_first_q), .we_i(pat_we),
    .wdata_i(in_data), .raddr_i('0), .rdata_o(pat_rdata),
    .len_o(pat_len), .ovf_o(pat_ovf), .mem_o(pat_mem)
  );

`ifdef SME_LOADER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] to_q;
  logic          to_hit;
  assign to_hit = (to_q == TW'(TIMEOUT - 1));

  // Counts cycles spent in WAIT; restarts whenever WAIT is left.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                to_q <= '0;
    else if (state_q == WAIT)  to_q <= to_q + 1'b1;
    else                       to_q <= '0;
  end
`else
  // TIMEOUT only matters when the WAIT watchdog is built.
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT == 0);
`endif

  // Record bookkeeping, FSM next state and next registered SME outputs.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    str_valid_d = str_valid_q;
    str_sent_d  = str_sent_q;
    pat_full_d  = pat_full_q;
    str_first_d = str_first_q;
    pat_first_d = pat_first_q;
    err_d       = err_q;
    pat_cnt_d   = pat_cnt_q;
    chardata_d  = '0;
    isstring_d  = 1'b0;
    ispattern_d = 1'b0;
    go_pat      = 1'b0;

    if (acc_str) begin
      if (str_first_q) begin
        str_valid_d = 1'b0;
        str_sent_d  = 1'b0;
      end
      str_first_d = in_last;
      if (in_last) str_valid_d = 1'b1;
      if (str_ovf) err_d = 1'b1;
    end

    if (acc_pat) begin
      pat_first_d = in_last;
      if (!str_valid_q) begin
        err_d = 1'b1;
      end else begin
        if (pat_ovf) err_d = 1'b1;
        if (in_last) pat_full_d = 1'b1;
      end
    end

    case (state_q)
      IDLE: begin
        if (acc_eos) begin
          state_d = DONE;
        end else if (pat_full_q && str_valid_q) begin
          if (!str_sent_q) begin
            state_d    = SEND_STR;
            isstring_d = 1'b1;
            chardata_d = str_rdata;
            idx_d      = IW'(1);
          end else begin
            go_pat = 1'b1;
          end
        end
      end
      SEND_STR: begin
        if (idx_q < IW'(str_len)) begin
          isstring_d = 1'b1;
          chardata_d = str_rdata;
          idx_d      = idx_q + 1'b1;
        end else begin
          str_sent_d = 1'b1;
          go_pat     = 1'b1;
        end
      end
      SEND_PAT: begin
        if (idx_q < IW'(iss_len_q)) begin
          ispattern_d = 1'b1;
          chardata_d  = iss_q[idx_q[PAW-1:0]];
          idx_d       = idx_q + 1'b1;
        end else begin
          state_d = WAIT;
          idx_d   = '0;
        end
      end
      WAIT: begin
        if (sme_valid) begin
          pat_cnt_d = pat_cnt_q + 1'b1;
          state_d   = IDLE;
        end
`ifdef SME_LOADER_TIMEOUT_EN
        else if (to_hit) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end
`endif
      end
      DONE:    state_d = DONE;
      default: state_d = IDLE;
    endcase

    // Entering SEND_PAT: first byte straight from the pattern buffer while
    // the rest is copied, freeing the buffer for the next pattern.
    if (go_pat) begin
      state_d     = SEND_PAT;
      ispattern_d = 1'b1;
      chardata_d  = pat_rdata;
      idx_d       = IW'(1);
      pat_full_d  = 1'b0;
    end
  end

  // Control and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      str_valid_q <= 1'b0;
      str_sent_q  <= 1'b0;
      pat_full_q  <= 1'b0;
      str_first_q <= 1'b1;
      pat_first_q <= 1'b1;
      err_q       <= 1'b0;
      pat_cnt_q   <= '0;
      chardata_q  <= '0;
      isstring_q  <= 1'b0;
      ispattern_q <= 1'b0;
      iss_len_q   <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      str_valid_q <= str_valid_d;
      str_sent_q  <= str_sent_d;
      pat_full_q  <= pat_full_d;
      str_first_q <= str_first_d;
      pat_first_q <= pat_first_d;
      err_q       <= err_d;
      pat_cnt_q   <= pat_cnt_d;
      chardata_q  <= chardata_d;
      isstring_q  <= isstring_d;
      ispattern_q <= ispattern_d;
      if (go_pat) iss_len_q <= pat_len;
    end
  end

  // Issue register: snapshot of the pattern being sent.
  always_ff @(posedge clk) begin
    if (go_pat) begin
      for (int i = 0; i < PAT_MAX; i++) iss_q[i] <= pat_mem[i*8 +: 8];
    end
  end

  assign chardata  = chardata_q;
  assign isstring  = isstring_q;
  assign ispattern = ispattern_q;
  assign pat_cnt   = pat_cnt_q;
  assign err       = err_q;
  assign busy      = (state_q == SEND_STR) || (state_q == SEND_PAT) || (state_q == WAIT);

endmodule

// File: tb/tb_sme_loader.sv
// Randomized bench for sme_loader with a queue-based reference model of
// the string/pattern replay, pattern count and sticky error flag.
module tb_sme_loader;
  import sme_pkg::*;

  logic       clk = 1'b0, reset = 1'b0;
  logic [7:0] in_data = '0;
  logic [1:0] in_type = '0;
  logic       in_last = 1'b0, in_valid = 1'b0, sme_valid = 1'b0;
  logic       in_ready, isstring, ispattern, busy, err;
  logic [7:0] chardata, pat_cnt;

  int vectors = 0, miscompares = 0, cyc = 0;

  typedef struct { bit s; bit p; logic [7:0] d; int c; } ev_t;
  typedef logic [7:0] bq_t[$];
  ev_t obs[$], exp_q[$];

  logic [7:0] m_str[$];
  bit m_valid = 0, m_sent = 0, m_err = 0;
  int m_cnt = 0;

  sme_loader dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_type(in_type),
    .in_last(in_last), .in_valid(in_valid), .in_ready(in_ready),
    .chardata(chardata), .isstring(isstring), .ispattern(ispattern),
    .sme_valid(sme_valid), .busy(busy), .pat_cnt(pat_cnt), .err(err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (isstring || ispattern) obs.push_back('{isstring, ispattern, chardata, cyc});

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "bench watchdog expired");
  end

  task automatic send_byte(input logic [1:0] t, input logic [7:0] d, input bit last);
    int n = 0;
    in_type = t; in_data = d; in_last = last; in_valid = 1'b1;
    #1;
    while (!in_ready && n < 300) begin @(negedge clk); #1; n++; end
    if (!in_ready) begin
      vectors++; miscompares++;
      $display("FAIL handshake_timeout: in_ready=%0b required=1 type=%0d", in_ready, t);
    end
    @(negedge clk);
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic load_string(input bq_t s);
    for (int i = 0; i < s.size(); i++) send_byte(TYPE_STR, s[i], i == s.size() - 1);
    m_str = {};
    for (int i = 0; i < s.size() && i < STR_MAX_DEF; i++) m_str.push_back(s[i]);
    if (s.size() > STR_MAX_DEF) m_err = 1;
    m_valid = 1; m_sent = 0;
  endtask

  task automatic load_pattern(input bq_t p);
    for (int i = 0; i < p.size(); i++) send_byte(TYPE_PAT, p[i], i == p.size() - 1);
    if (!m_valid) begin
      m_err = 1;
    end else begin
      if (!m_sent) begin
        foreach (m_str[i]) exp_q.push_back('{1'b1, 1'b0, m_str[i], 0});
        m_sent = 1;
      end
      for (int i = 0; i < p.size() && i < PAT_MAX_DEF; i++) exp_q.push_back('{1'b0, 1'b1, p[i], 0});
      if (p.size() > PAT_MAX_DEF) m_err = 1;
    end
  endtask

  task automatic rand_bytes(input int n, output bq_t q);
    q = {};
    for (int i = 0; i < n; i++) q.push_back(8'($urandom_range(8'h20, 8'h7e)));
  endtask

  task automatic check_issue(input string name);
    int n = 0;
    while (obs.size() < exp_q.size() && n < 400) begin @(negedge clk); n++; end
    repeat (3) @(negedge clk);
    vectors++;
    if (obs.size() != exp_q.size()) begin
      miscompares++;
      $display("FAIL %s_count: got %0d strobes, required %0d", name, obs.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs.size(); i++) begin
      vectors++;
      if ({obs[i].s, obs[i].p, obs[i].d} !== {exp_q[i].s, exp_q[i].p, exp_q[i].d}) begin
        miscompares++;
        $display("FAIL %s_byte[%0d]: got s=%0b p=%0b d=%h, required s=%0b p=%0b d=%h", name, i,
                 obs[i].s, obs[i].p, obs[i].d, exp_q[i].s, exp_q[i].p, exp_q[i].d);
      end
      if (i > 0) begin
        vectors++;
        if (obs[i].c != obs[i-1].c + 1) begin
          miscompares++;
          $display("FAIL %s_gap[%0d]: strobe at cycle %0d, required %0d", name, i, obs[i].c, obs[i-1].c + 1);
        end
      end
    end
    obs.delete(); exp_q.delete();
  endtask

  task automatic pulse_sme(output int c);
    sme_valid = 1'b1; c = cyc;
    @(negedge clk);
    sme_valid = 1'b0;
  endtask

  task automatic finish_job(input string name, output int c);
    vectors++;
    if (busy !== 1'b1 || {isstring, ispattern, chardata} !== 10'd0) begin
      miscompares++;
      $display("FAIL %s_wait: busy=%0b s=%0b p=%0b d=%h, required busy=1 and zero outputs", name, busy, isstring, ispattern, chardata);
    end
    pulse_sme(c);
    m_cnt++;
    vectors++;
    if (pat_cnt !== 8'(m_cnt)) begin
      miscompares++;
      $display("FAIL %s_patcnt: got %0d, required %0d", name, pat_cnt, 8'(m_cnt));
    end
    vectors++;
    if (err !== m_err) begin
      miscompares++;
      $display("FAIL %s_err: got %0b, required %0b", name, err, m_err);
    end
  endtask

  task automatic model_reset();
    m_str = {}; m_valid = 0; m_sent = 0; m_err = 0; m_cnt = 0;
    obs.delete(); exp_q.delete();
  endtask

  task automatic test_reset();
    int c;
    repeat (3) @(negedge clk);
    vectors++;
    if ({in_ready, isstring, ispattern, busy, err} !== 5'd0 || chardata !== 8'd0 || pat_cnt !== 8'd0) begin
      miscompares++;
      $display("FAIL reset_outputs: rdy=%0b s=%0b p=%0b busy=%0b err=%0b d=%h cnt=%0d, required all 0",
               in_ready, isstring, ispattern, busy, err, chardata, pat_cnt);
    end
    reset = 1'b1;
    @(negedge clk);
    vectors++;
    if (in_ready !== 1'b1) begin
      miscompares++; $display("FAIL idle_ready: got %0b, required 1", in_ready);
    end
    pulse_sme(c);
    @(negedge clk);
    vectors++;
    if (pat_cnt !== 8'd0 || busy !== 1'b0) begin
      miscompares++; $display("FAIL idle_sme_ignored: cnt=%0d busy=%0b, required 0 0", pat_cnt, busy);
    end
  endtask

  task automatic test_basic();
    bq_t s, p; int c;
    s = {8'h61, 8'h62, CH_SPACE, 8'h63, 8'h64};
    p = {8'h63, 8'h64};
    load_string(s);
    load_pattern(p);
    check_issue("basic");
    finish_job("basic", c);
  endtask

  task automatic test_second_and_wait_load();
    bq_t p; int c, n;
    p = {CH_HAT, 8'h61};
    load_pattern(p);
    check_issue("second");
    in_type = TYPE_PAT; #1;
    vectors++;
    if (in_ready !== 1'b1 || busy !== 1'b1) begin
      miscompares++; $display("FAIL wait_ready: rdy=%0b busy=%0b, required 1 1", in_ready, busy);
    end
    @(negedge clk);
    p = {CH_DOT, 8'h64, CH_DOLLAR};
    load_pattern(p);
    vectors++;
    if (obs.size() != 0 || busy !== 1'b1) begin
      miscompares++; $display("FAIL wait_hold: strobes=%0d busy=%0b, required 0 1", obs.size(), busy);
    end
    finish_job("second", c);
    n = 0;
    while (obs.size() == 0 && n < 20) begin @(negedge clk); n++; end
    vectors++;
    if (obs.size() == 0 || obs[0].c != c + 2) begin
      miscompares++;
      $display("FAIL wait_latency: first ispattern at cycle %0d, required %0d", (obs.size() == 0) ? -1 : obs[0].c, c + 2);
    end
    check_issue("wait_load");
    finish_job("wait_load", c);
  endtask

  task automatic test_random();
    bq_t s, p; int c;
    for (int j = 0; j < 6; j++) begin
      if (j == 0 || $urandom_range(0, 1) == 1) begin
        rand_bytes($urandom_range(1, STR_MAX_DEF), s);
        load_string(s);
      end
      rand_bytes($urandom_range(1, PAT_MAX_DEF), p);
      load_pattern(p);
      check_issue("random");
      finish_job("random", c);
    end
  endtask

  task automatic test_overflow();
    bq_t s, p; int c;
    rand_bytes(34, s);
    load_string(s);
    vectors++;
    if (err !== 1'b1) begin
      miscompares++; $display("FAIL str_overflow_err: got %0b, required 1", err);
    end
    rand_bytes(3, p);
    load_pattern(p);
    check_issue("str_overflow");
    finish_job("str_overflow", c);
    rand_bytes(10, p);
    load_pattern(p);
    check_issue("pat_overflow");
    finish_job("pat_overflow", c);
  endtask

  task automatic test_eos();
    send_byte(TYPE_EOS, 8'h00, 1'b0);
    repeat (3) @(negedge clk);
    vectors++;
    if (busy !== 1'b0 || obs.size() != 0) begin
      miscompares++; $display("FAIL eos_done: busy=%0b strobes=%0d, required 0 0", busy, obs.size());
    end
    for (int t = 0; t < 3; t++) begin
      in_type = 2'(t); #1;
      vectors++;
      if (in_ready !== 1'b0) begin
        miscompares++; $display("FAIL eos_ready[%0d]: got %0b, required 0", t, in_ready);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    bq_t s, p; int c, n;
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    model_reset();
    @(negedge clk);
    rand_bytes(4, s); rand_bytes(2, p);
    load_string(s); load_pattern(p);
    check_issue("post_reset");
    finish_job("post_reset", c);
    rand_bytes(20, s); rand_bytes(4, p);
    load_string(s); load_pattern(p);
    n = 0;
    while (obs.size() < 3 && n < 50) begin @(negedge clk); n++; end
    #2 reset = 1'b0;
    #1;
    vectors++;
    if ({isstring, ispattern, busy} !== 3'd0 || chardata !== 8'd0 || pat_cnt !== 8'd0) begin
      miscompares++;
      $display("FAIL reset_mid: s=%0b p=%0b busy=%0b d=%h cnt=%0d, required all 0", isstring, ispattern, busy, chardata, pat_cnt);
    end
    @(negedge clk);
    reset = 1'b1;
    model_reset();
    @(negedge clk);
  endtask

`ifdef SME_LOADER_TIMEOUT_EN
  task automatic test_timeout();
    bq_t s, p;
    rand_bytes(3, s); rand_bytes(2, p);
    load_string(s); load_pattern(p);
    check_issue("timeout");
    repeat (70) @(negedge clk);
    vectors++;
    if (err !== 1'b1 || busy !== 1'b0 || pat_cnt !== 8'(m_cnt)) begin
      miscompares++;
      $display("FAIL timeout: err=%0b busy=%0b cnt=%0d, required 1 0 %0d", err, busy, pat_cnt, 8'(m_cnt));
    end
    m_err = 1;
  endtask
`endif

  task automatic test_pattern_no_string();
    bq_t s, p; int c;
    send_byte(TYPE_PAT, 8'h41, 1'b1);
    m_err = 1;
    repeat (3) @(negedge clk);
    vectors++;
    if (err !== 1'b1 || busy !== 1'b0 || obs.size() != 0) begin
      miscompares++;
      $display("FAIL pat_drop: err=%0b busy=%0b strobes=%0d, required 1 0 0", err, busy, obs.size());
    end
    rand_bytes(5, s); rand_bytes(3, p);
    load_string(s); load_pattern(p);
    check_issue("after_drop");
    finish_job("after_drop", c);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_second_and_wait_load();
    test_random();
    test_overflow();
    test_eos();
    test_reset_mid();
`ifdef SME_LOADER_TIMEOUT_EN
    test_timeout();
`endif
    test_pattern_no_string();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
